// File: rtl/div_repsub_if.sv
// Start/done handshake and operand/result bus shared by the divider and its requester.
interface div_repsub_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic [WIDTH-1:0] data_in;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             busy;
  logic             done;
  logic             dbz;

  // Requester side: issues start and operands, observes results.
  modport master (
    output start, data_in,
    input  quotient, remainder, busy, done, dbz
  );

  // Divider side.
  modport slave (
    input  start, data_in,
    output quotient, remainder, busy, done, dbz
  );
endinterface

// File: rtl/div_repsub.sv
// Unsigned divider by repeated subtraction. Dividend and divisor arrive on
// consecutive cycles after a start pulse. One subtraction is made per cycle
// until the remainder drops below the divisor. A zero divisor is reported
// through dbz with an all-ones quotient.
module div_repsub #(
  parameter int WIDTH = 16
) (
  input  logic        clk,
  input  logic        rst,
  div_repsub_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LDA  = 3'd1,
    LDB  = 3'd2,
    CHK  = 3'd3,
    SUB  = 3'd4,
    DONE = 3'd5
  } state_t;

  state_t           state_reg;
  logic [WIDTH-1:0] quotient_reg;
  logic [WIDTH-1:0] remainder_reg;
  logic [WIDTH-1:0] divisor_reg;
  logic             busy_reg;
  logic             done_reg;
  logic             dbz_reg;

  // Controller and datapath. busy/done are updated on the same edges that
  // change state, so they always match the state being entered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      quotient_reg  <= '0;
      remainder_reg <= '0;
      divisor_reg   <= '0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
      dbz_reg       <= 1'b0;
    end else begin
      case (state_reg)
        IDLE, DONE: begin
          // Results stay held in DONE until the next start is accepted.
          if (bus.start) begin
            state_reg <= LDA;
            busy_reg  <= 1'b1;
            done_reg  <= 1'b0;
          end
        end
        LDA: begin
          // The remainder register receives the dividend. It is then reduced in place.
          remainder_reg <= bus.data_in;
          quotient_reg  <= '0;
          dbz_reg       <= 1'b0;
          state_reg     <= LDB;
        end
        LDB: begin
          divisor_reg <= bus.data_in;
          state_reg   <= CHK;
        end
        CHK: begin
          if (divisor_reg == '0) begin
            quotient_reg <= '1;
            dbz_reg      <= 1'b1;
            state_reg    <= DONE;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b1;
          end else begin
            state_reg <= SUB;
          end
        end
        SUB: begin
          if (remainder_reg >= divisor_reg) begin
            remainder_reg <= remainder_reg - divisor_reg;
            quotient_reg  <= quotient_reg + 1'b1;
          end else begin
            state_reg <= DONE;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b1;
          end
        end
        default: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
          done_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.quotient  = quotient_reg;
  assign bus.remainder = remainder_reg;
  assign bus.busy      = busy_reg;
  assign bus.done      = done_reg;
  assign bus.dbz       = dbz_reg;

endmodule
